// File: rtl/alu_pkg.sv
// Shared definitions for the ALU matrix operations.
package alu_pkg;

   localparam int MATRIX_DIM = 5;
   localparam int ELEM_W     = 8;
   localparam int NUM_ELEMS  = MATRIX_DIM * MATRIX_DIM;
   localparam int FLAT_W     = NUM_ELEMS * ELEM_W;

   localparam logic signed [7:0] INT8_MIN = -8'sd128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ITER,
      S_WRITE,
      S_DONE
   } div_state_e;

endpackage

// File: rtl/div8_unit.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
module div8_unit #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   input  logic         step,
   output logic [W-1:0] quotient,
   output logic         ready
);

   localparam int CW = $clog2(W + 1);

   logic [W:0]    rem;
   logic [W-1:0]  q;
   logic [W-1:0]  d;
   logic [CW-1:0] cnt;
   logic [W+1:0]  trial;

   // Shift the next dividend bit into the remainder and try subtracting the divisor.
   // The remainder always stays below the divisor, so the top bit of trial is its sign.
   assign trial    = {rem, q[W-1]} - {2'b00, d};
   assign quotient = q;
   assign ready    = (cnt == CW'(W));

   // Load a new operand pair, or perform one restoring step; q doubles as the
   // dividend shift register and the quotient accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         q   <= '0;
         d   <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= '0;
         q   <= dividend;
         d   <= divisor;
         cnt <= '0;
      end else if (step) begin
         rem <= trial[W+1] ? {rem[W-1:0], q[W-1]} : trial[W:0];
         q   <= {q[W-2:0], ~trial[W+1]};
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_scalar_div_module.sv
// Matrix / scalar signed division, one element at a time through a shared divider.
module alu_scalar_div_module
   import alu_pkg::*;
#(
   parameter int MATRIX_DIM = alu_pkg::MATRIX_DIM,
   parameter int ELEM_W     = alu_pkg::ELEM_W
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [MATRIX_DIM*MATRIX_DIM*ELEM_W-1:0] A_flat,
   input  logic signed [ELEM_W-1:0]               scalar,
   output logic [MATRIX_DIM*MATRIX_DIM*ELEM_W-1:0] C_flat,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   div_by_zero_flag,
   output logic                                   overflow_flag
);

   localparam int N_EL  = MATRIX_DIM * MATRIX_DIM;
   localparam int IDX_W = $clog2(N_EL);
   localparam int CNT_W = $clog2(ELEM_W);
   localparam logic [ELEM_W-1:0] ELEM_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

   div_state_e state;

   logic [N_EL-1:0][ELEM_W-1:0] a_cap;
   logic [N_EL-1:0][ELEM_W-1:0] c_mat;
   logic signed [ELEM_W-1:0]    s_cap;
   logic [IDX_W-1:0]            idx;
   logic [CNT_W-1:0]            it_cnt;
   logic                        q_neg;

   logic [ELEM_W-1:0] a_cur;
   logic [ELEM_W-1:0] a_mag;
   logic [ELEM_W-1:0] s_mag;
   logic [ELEM_W-1:0] quo;
   logic [ELEM_W-1:0] res;
   logic              div_load;
   logic              div_step;
   logic              div_ready;
   logic              is_ovf;

   assign C_flat = c_mat;

   // Magnitudes are unsigned so that |-128| = 128 fits in ELEM_W bits.
   assign a_cur = a_cap[idx];
   assign a_mag = a_cur[ELEM_W-1] ? (~a_cur + 1'b1) : a_cur;
   assign s_mag = s_cap[ELEM_W-1] ? (~s_cap + 1'b1) : s_cap;

   // Two's-complement negate; a zero quotient negates to zero.
   assign res    = q_neg ? (~quo + 1'b1) : quo;
   assign is_ovf = (a_cur == ELEM_MIN) && (s_cap == '1);

   assign div_load = (state == S_SETUP);
   assign div_step = (state == S_ITER) && !div_ready;

   div8_unit #(.W(ELEM_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .dividend (a_mag),
      .divisor  (s_mag),
      .step     (div_step),
      .quotient (quo),
      .ready    (div_ready)
   );

   // Control FSM: capture, per-element sequencing, result write-back and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         a_cap            <= '0;
         s_cap            <= '0;
         c_mat            <= '0;
         idx              <= '0;
         it_cnt           <= '0;
         q_neg            <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         div_by_zero_flag <= 1'b0;
         overflow_flag    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_cap            <= A_flat;
                  s_cap            <= scalar;
                  c_mat            <= '0;
                  idx              <= '0;
                  overflow_flag    <= 1'b0;
                  div_by_zero_flag <= 1'b0;
                  if (scalar == '0) begin
                     // Nothing to divide: finish immediately with an all-zero result.
                     div_by_zero_flag <= 1'b1;
                     done             <= 1'b1;
                     state            <= S_DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               it_cnt <= '0;
               q_neg  <= a_cur[ELEM_W-1] ^ s_cap[ELEM_W-1];
               state  <= S_ITER;
            end
            S_ITER: begin
               it_cnt <= it_cnt + 1'b1;
               if (it_cnt == CNT_W'(ELEM_W - 1))
                  state <= S_WRITE;
            end
            S_WRITE: begin
               // -128 / -1 has magnitude 128 with positive sign, which wraps to 8'h80.
               c_mat[idx] <= res;
               if (is_ovf)
                  overflow_flag <= 1'b1;
               if (idx == IDX_W'(N_EL - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_SETUP;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_scalar_div_module.md
# alu_scalar_div_module

- Divides every element of a flattened 5x5 signed 8-bit matrix by a signed 8-bit scalar; each quotient is truncated toward zero.
- It is the inverse-direction partner of the ALU's combinational scalar multiply.
- It is sequential: a shared restoring divider processes the 25 elements in turn, element 0 first, and writes the quotients into a registered result matrix.
- It sits beside the other ALU matrix operations and is controlled by the coprocessor controller with a start/done handshake.

## Interface
- `MATRIX_DIM`, default 5: rows/cols of the square matrix.
- `ELEM_W`, default 8: element and scalar width in bits.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `start` in, 1: request an operation; sampled only in IDLE.
- `A_flat` in, 200: dividend matrix; element i is at `[(i*8)+:8]`, signed.
- `scalar` in, 8, signed: divisor.
- `C_flat` out, 200: quotient matrix, same packing; registered.
- `busy` out, 1: operation in progress.
- `done` out, 1: one-cycle completion pulse.
- `div_by_zero_flag` out, 1: the captured scalar was 0. Sticky until the next accepted start.
- `overflow_flag` out, 1: some element computed -128 / -1. Sticky until the next accepted start.

## Operation
- **States:** IDLE, SETUP, ITER, WRITE, DONE.
- **IDLE, start=1:**
  - Capture `A_flat` and `scalar` into internal registers.
  - Clear `C_flat` and both flags.
  - Set element index i=0.
  - If scalar==0: set `div_by_zero_flag` and go to DONE, leaving `C_flat` all zeros. Otherwise go to SETUP.
- **SETUP:**
  - Load |a_i| as 8-bit unsigned; 128 is representable.
  - Load |scalar|.
  - Clear the 9-bit partial remainder and the iteration counter.
  - Latch quotient sign = sign(a_i) XOR sign(scalar).
- **ITER:**
  - One restoring-division step per cycle, MSB first, for exactly 8 cycles.
  - Then go to WRITE.
- **WRITE:**
  - Negate the unsigned quotient if the sign is set. A zero quotient stays 0, never negative zero.
  - Write the result to `C_flat[(i*8)+:8]`.
  - If a_i==-128 and scalar==-1: write 8'h80 (wrapped) and set `overflow_flag`.
  - If i==24 go to DONE; else i++ and go to SETUP.
- **DONE:** `done`=1 for this one cycle, then go to IDLE.
- **Results:**
  - The remainder is discarded.
  - Examples: 7/2=3, -7/2=-3, 7/-2=-3, -7/-2=3, 1/5=0, -128/1=-128 (no overflow), 127/-1=-127.
- **Captured inputs:** `A_flat` and `scalar` changes after capture have no effect.
- **start while busy:** start when not in IDLE is ignored; there is no queueing.
- **start during DONE:** start in the DONE cycle is ignored. A new start is accepted in the next IDLE cycle at the earliest.

## Timing
- **Reset values:**
  - `rst` high at any clock edge, including mid-operation, forces IDLE.
  - `C_flat`=0, `busy`=0, `done`=0, both flags 0.
  - Captured inputs and the index are cleared.
- **Edges:** let E0 be the edge at which start is accepted.
- **Per-element cost:** 10 cycles (SETUP 1 + ITER 8 + WRITE 1).
- **Nonzero scalar:**
  - Element i is written at edge E0+10*(i+1).
  - Element 24 is written at E250.
  - `done` is high during the cycle after E250 and falls at E251.
- **`busy`:**
  - Rises at E0 and is high from E0 through E250.
  - It is low in the `done` cycle.
- **Zero scalar:**
  - `done` is high during the cycle after E0 and falls at E1.
  - `busy` is never asserted.
- **Back-to-back:** start held high continuously re-triggers one cycle after `done` falls, i.e. it is accepted at edge E252.
- **`C_flat` during operation:**
  - Intermediate values are observable: elements not yet written read 0.
  - Consumers sample `C_flat` only when `done`=1 or afterwards.
- **Result hold:** `C_flat` and the flags hold until the next accepted start or reset.

## Structure
- **Shared package `alu_pkg`:**
  - `MATRIX_DIM`, `ELEM_W`, `NUM_ELEMS`=25.
  - Flattened-matrix width 200.
  - The state enum for this block.
  - The int8 min constant -128.
- **Sub-module `div8_unit`:**
  - Unsigned 8/8 restoring divider, one bit per cycle.
  - Ports: `load`, dividend, divisor, `step`, quotient, `ready`.
  - Instantiated once; the top-level FSM handles sign, index sequencing and flags.

## Test plan
- **Basic:** A all 7, scalar=2.
  - Every element = 3.
  - `done` exactly at cycle 251 after start.
  - Flags 0.
- **Signs:** A elements {-7, 7, -7, 0, 1, ...} with scalar=-2.
  - Results {3, -3, 3, 0, 0, ...}.
  - No element reads as 8'h80 unless it is the true result.
- **Divide-by-zero:** scalar=0.
  - `done` one cycle after start.
  - `C_flat`=0.
  - `div_by_zero_flag`=1.
  - `busy` never high.
- **Overflow:** element 12 = -128, scalar=-1, all others 5.
  - Element 12 = 8'h80, others = -5.
  - `overflow_flag`=1 at `done`.
  - A subsequent start with scalar=1 clears the flag.
- **Reset mid-operation:** assert `rst` at cycle 100.
  - All outputs 0 next cycle, state IDLE.
  - A fresh start completes correctly in 251 cycles.
- **Ignored start and input changes:** pulse start at cycle 50 of an operation and change `A_flat`/`scalar` mid-operation.
  - Results reflect the originally captured inputs only.
  - Single `done` pulse.
